// File: rtl/keypad_lock_ctrl.sv
// Keypad combination lock: synchronises and debounces the Decoder ping and emits one event per press.
// It also assembles the entered code and runs the lock state machine (check, open, program, lockout).
module keypad_lock_ctrl #(
  parameter int                  DIGITS          = 4,
  parameter int                  DEBOUNCE_CYCLES = 1_000_000,
  parameter int                  MAX_FAILS       = 3,
  parameter int                  LOCKOUT_CYCLES  = 500_000_000,
  parameter logic [4*DIGITS-1:0] DEFAULT_CODE    = 16'h1234
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   key_code,
  input  logic                         key_ping,
  output logic                         key_evt,
  output logic [3:0]                   key_val,
  output logic [$clog2(DIGITS+1)-1:0]  digit_cnt,
  output logic                         unlocked,
  output logic                         lockout,
  output logic                         err,
  output logic                         code_saved,
  output logic [3:0]                   disp_val
);

  localparam int CW   = $clog2(DIGITS + 1);
  localparam int BW   = 4 * DIGITS;
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LO_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int FW   = (MAX_FAILS > 1) ? $clog2(MAX_FAILS + 1) : 1;

  localparam logic [DB_W-1:0] DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LO_W-1:0] LO_MAX   = LO_W'(LOCKOUT_CYCLES - 1);
  localparam logic [FW-1:0]   FAIL_MAX = FW'(MAX_FAILS - 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(DIGITS);

  typedef enum logic [2:0] {
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_PROG,
    ST_LOCKOUT
  } state_t;

  // Input synchronisers and debouncer
  logic            ping_s1_q, ping_s2_q;
  logic [3:0]      code_s1_q, code_s2_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            stable_q, stable_d;
  logic            stable_prev_q;
  logic            key_evt_q, key_evt_d;
  logic [3:0]      key_val_q, key_val_d;

  // Lock state
  state_t          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [BW-1:0]   code_q, code_d;
  logic [CW-1:0]   digit_cnt_q, digit_cnt_d;
  logic [3:0]      disp_q, disp_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic [LO_W-1:0] lock_cnt_q, lock_cnt_d;
  logic            err_q, err_d;
  logic            saved_q, saved_d;

  always_comb begin
    db_cnt_d = db_cnt_q;
    stable_d = stable_q;
    // The counter only advances while the synced ping disagrees with the stable level,
    // so any flip back to the stable level restarts the window.
    if (ping_s2_q == stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_MAX) begin
      stable_d = ping_s2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
    key_evt_d = stable_q & ~stable_prev_q;
    key_val_d = key_evt_d ? code_s2_q : key_val_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ping_s1_q     <= 1'b0;
      ping_s2_q     <= 1'b0;
      code_s1_q     <= '0;
      code_s2_q     <= '0;
      db_cnt_q      <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      key_evt_q     <= 1'b0;
      key_val_q     <= '0;
    end else begin
      ping_s1_q     <= key_ping;
      ping_s2_q     <= ping_s1_q;
      code_s1_q     <= key_code;
      code_s2_q     <= code_s1_q;
      db_cnt_q      <= db_cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      key_evt_q     <= key_evt_d;
      key_val_q     <= key_val_d;
    end
  end

  logic is_digit, is_enter, is_clear, is_prog, full, clr_buf;

  always_comb begin
    is_digit = key_evt_q && (key_val_q <= 4'd9);
    is_enter = key_evt_q && (key_val_q == 4'hA);
    is_clear = key_evt_q && (key_val_q == 4'hB);
    is_prog  = key_evt_q && (key_val_q == 4'hC);
    full     = (digit_cnt_q == FULL_CNT);

    state_d     = state_q;
    buf_d       = buf_q;
    code_d      = code_q;
    digit_cnt_d = digit_cnt_q;
    disp_d      = disp_q;
    fail_d      = fail_q;
    lock_cnt_d  = lock_cnt_q;
    err_d       = 1'b0;
    saved_d     = 1'b0;
    clr_buf     = 1'b0;

    // Digits arriving with a full buffer are dropped without complaint.
    if (is_digit && !full && (state_q == ST_ENTRY || state_q == ST_PROG)) begin
      buf_d        = buf_q << 4;
      buf_d[3:0]   = key_val_q;
      digit_cnt_d  = digit_cnt_q + 1'b1;
      disp_d       = key_val_q;
    end

    case (state_q)
      ST_ENTRY: begin
        if (is_clear) begin
          clr_buf = 1'b1;
        end else if (is_enter) begin
          if (full) begin
            state_d = ST_CHECK;
          end else begin
            err_d   = 1'b1;
            clr_buf = 1'b1;
          end
        end
      end
      ST_CHECK: begin
        clr_buf = 1'b1;
        if (buf_q == code_q) begin
          state_d = ST_OPEN;
          fail_d  = '0;
        end else begin
          err_d = 1'b1;
          if (fail_q == FAIL_MAX) begin
            state_d    = ST_LOCKOUT;
            fail_d     = '0;
            lock_cnt_d = '0;
          end else begin
            state_d = ST_ENTRY;
            fail_d  = fail_q + 1'b1;
          end
        end
      end
      ST_OPEN: begin
        if (is_clear) begin
          state_d = ST_ENTRY;
        end else if (is_prog) begin
          state_d = ST_PROG;
          clr_buf = 1'b1;
        end
      end
      ST_PROG: begin
        if (is_enter) begin
          clr_buf = 1'b1;
          if (full) begin
            code_d  = buf_q;
            saved_d = 1'b1;
            state_d = ST_OPEN;
          end else begin
            err_d = 1'b1;
          end
        end else if (is_clear) begin
          // Cancelling programming also discards any partially typed new code.
          clr_buf = 1'b1;
          state_d = ST_OPEN;
        end
      end
      ST_LOCKOUT: begin
        if (lock_cnt_q == LO_MAX) begin
          state_d    = ST_ENTRY;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_ENTRY;
        clr_buf = 1'b1;
      end
    endcase

    if (clr_buf) begin
      buf_d       = '0;
      digit_cnt_d = '0;
      disp_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_ENTRY;
      buf_q       <= '0;
      code_q      <= DEFAULT_CODE;
      digit_cnt_q <= '0;
      disp_q      <= '0;
      fail_q      <= '0;
      lock_cnt_q  <= '0;
      err_q       <= 1'b0;
      saved_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      code_q      <= code_d;
      digit_cnt_q <= digit_cnt_d;
      disp_q      <= disp_d;
      fail_q      <= fail_d;
      lock_cnt_q  <= lock_cnt_d;
      err_q       <= err_d;
      saved_q     <= saved_d;
    end
  end

  assign key_evt    = key_evt_q;
  assign key_val    = key_val_q;
  assign digit_cnt  = digit_cnt_q;
  assign disp_val   = disp_q;
  assign err        = err_q;
  assign code_saved = saved_q;
  assign unlocked   = (state_q == ST_OPEN) || (state_q == ST_PROG);
  assign lockout    = (state_q == ST_LOCKOUT);

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Scoreboard bench for keypad_lock_ctrl: directed key sequences push expected output events,
// and a negedge monitor pops and compares every observed event.
module tb_keypad_lock_ctrl;

  localparam int DEB = 4;
  localparam int LOC = 20;

  localparam int K_KEY  = 0;
  localparam int K_ERR  = 1;
  localparam int K_SAVE = 2;
  localparam int K_UNL  = 3;
  localparam int K_LON  = 4;
  localparam int K_LOFF = 5;
  localparam int K_DISP = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       key_ping = 1'b0;
  logic       key_evt;
  logic [3:0] key_val;
  logic [2:0] digit_cnt;
  logic       unlocked, lockout, err, code_saved;
  logic [3:0] disp_val;

  keypad_lock_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .LOCKOUT_CYCLES (LOC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_code  (key_code),
    .key_ping  (key_ping),
    .key_evt   (key_evt),
    .key_val   (key_val),
    .digit_cnt (digit_cnt),
    .unlocked  (unlocked),
    .lockout   (lockout),
    .err       (err),
    .code_saved(code_saved),
    .disp_val  (disp_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  task automatic push(input int k, input logic [7:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // Monitor: fixed per-cycle order key, err, saved, unlocked, lockout on/off, display
  logic       unl_prev  = 1'b0;
  logic       lock_prev = 1'b0;
  logic [7:0] disp_prev = 8'h00;
  int         lock_len  = 0;

  task automatic mon_chk(input int k, input logic [7:0] v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[%0t] FAIL event: actual kind=%0d val=%h, required no event", $time, k, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val !== v) begin
        errors++;
        $display("[%0t] FAIL event: actual kind=%0d val=%h, required kind=%0d val=%h",
                 $time, k, v, e.kind, e.val);
      end else begin
        $display("[%0t] event kind=%0d val=%h ok", $time, k, v);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (key_evt) mon_chk(K_KEY, {4'h0, key_val});
      if (err) mon_chk(K_ERR, 8'h00);
      if (code_saved) mon_chk(K_SAVE, 8'h00);
      if (unlocked != unl_prev) mon_chk(K_UNL, {7'h0, unlocked});
      if (lockout) lock_len++;
      if (lockout && !lock_prev) mon_chk(K_LON, 8'h00);
      if (!lockout && lock_prev) begin
        mon_chk(K_LOFF, 8'(lock_len));
        lock_len = 0;
      end
      if ({1'b0, digit_cnt, disp_val} != disp_prev) mon_chk(K_DISP, {1'b0, digit_cnt, disp_val});
      unl_prev  = unlocked;
      lock_prev = lockout;
      disp_prev = {1'b0, digit_cnt, disp_val};
    end
  end

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_code = k;
    key_ping = 1'b1;
    repeat (8) @(negedge clk);
    key_ping = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic dig(input logic [3:0] d, input logic [3:0] c);
    push(K_KEY, {4'h0, d});
    push(K_DISP, {c, d});
    press(d);
  endtask

  task automatic key_only(input logic [3:0] k);
    push(K_KEY, {4'h0, k});
    press(k);
  endtask

  task automatic enter_open;
    push(K_KEY, 8'h0A);
    push(K_UNL, 8'h01);
    push(K_DISP, 8'h00);
    press(4'hA);
  endtask

  task automatic enter_wrong(input bit to_lockout);
    push(K_KEY, 8'h0A);
    push(K_ERR, 8'h00);
    if (to_lockout) push(K_LON, 8'h00);
    push(K_DISP, 8'h00);
    press(4'hA);
  endtask

  task automatic lock_with_b;
    push(K_KEY, 8'h0B);
    push(K_UNL, 8'h00);
    press(4'hB);
  endtask

  int lat;
  bit found;

  initial begin
    repeat (3) @(negedge clk);
    checks++;
    if ({key_evt, key_val, digit_cnt, unlocked, lockout, err, code_saved, disp_val} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: actual %b, required all zero",
               {key_evt, key_val, digit_cnt, unlocked, lockout, err, code_saved, disp_val});
    end else begin
      $display("reset outputs all zero ok");
    end
    reset = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // 1: 3-cycle glitch, 1-cycle dropout, then a 10-cycle hold gives one press
    push(K_KEY, 8'h07);
    push(K_DISP, 8'h17);
    @(negedge clk);
    key_code = 4'h7;
    key_ping = 1'b1;
    repeat (3) @(negedge clk);
    key_ping = 1'b0;
    @(negedge clk);
    key_ping = 1'b1;
    lat = 0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (key_evt) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || lat != DEB + 3) begin
      errors++;
      $display("FAIL press_latency: actual %0d (seen=%0d), required %0d", lat, found, DEB + 3);
    end else begin
      $display("press latency %0d cycles ok", lat);
    end
    repeat (10 - lat) @(negedge clk);
    key_ping = 1'b0;
    repeat (12) @(negedge clk);
    push(K_KEY, 8'h0B);
    push(K_DISP, 8'h00);
    press(4'hB);

    // 2: default code opens the lock
    dig(4'h1, 4'd1); dig(4'h2, 4'd2); dig(4'h3, 4'd3); dig(4'h4, 4'd4);
    enter_open();
    lock_with_b();

    // 3: short entry, then an overfull entry keeps only the first four digits
    dig(4'h1, 4'd1); dig(4'h2, 4'd2);
    push(K_KEY, 8'h0A);
    push(K_ERR, 8'h00);
    push(K_DISP, 8'h00);
    press(4'hA);
    dig(4'h1, 4'd1); dig(4'h2, 4'd2); dig(4'h3, 4'd3); dig(4'h4, 4'd4);
    key_only(4'h5);
    enter_open();
    lock_with_b();

    // 4: three wrong codes lock out; a key during lockout only pulses key_evt
    for (int n = 0; n < 3; n++) begin
      dig(4'h9, 4'd1); dig(4'h9, 4'd2); dig(4'h9, 4'd3); dig(4'h9, 4'd4);
      enter_wrong(n == 2);
    end
    push(K_KEY, 8'h05);
    push(K_LOFF, 8'(LOC));
    press(4'h5);
    repeat (5) @(negedge clk);

    // 5: program 5678, old code rejected, new code accepted
    dig(4'h1, 4'd1); dig(4'h2, 4'd2); dig(4'h3, 4'd3); dig(4'h4, 4'd4);
    enter_open();
    key_only(4'hC);
    dig(4'h5, 4'd1); dig(4'h6, 4'd2); dig(4'h7, 4'd3); dig(4'h8, 4'd4);
    push(K_KEY, 8'h0A);
    push(K_SAVE, 8'h00);
    push(K_DISP, 8'h00);
    press(4'hA);
    lock_with_b();
    dig(4'h1, 4'd1); dig(4'h2, 4'd2); dig(4'h3, 4'd3); dig(4'h4, 4'd4);
    enter_wrong(1'b0);
    dig(4'h5, 4'd1); dig(4'h6, 4'd2); dig(4'h7, 4'd3); dig(4'h8, 4'd4);
    enter_open();

    // 6: reset while programming with two digits buffered
    key_only(4'hC);
    dig(4'h1, 4'd1); dig(4'h2, 4'd2);
    push(K_UNL, 8'h00);
    push(K_DISP, 8'h00);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({key_evt, key_val, digit_cnt, unlocked, lockout, err, code_saved, disp_val} !== '0) begin
      errors++;
      $display("FAIL midop_reset: actual %b, required all zero",
               {key_evt, key_val, digit_cnt, unlocked, lockout, err, code_saved, disp_val});
    end else begin
      $display("mid-operation reset outputs all zero ok");
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    dig(4'h1, 4'd1); dig(4'h2, 4'd2); dig(4'h3, 4'd3); dig(4'h4, 4'd4);
    enter_open();

    repeat (30) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: actual %0d outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
